// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch_counter slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_U_MAX = 4'd9;
  localparam bcd_t SEC_T_MAX = 4'd5;
  localparam bcd_t MIN_U_MAX = 4'd9;
  localparam bcd_t MIN_T_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control pulses, divided tick and BCD display outputs of stopwatch_counter.
interface stopwatch_counter_if;
  import stopwatch_pkg::*;

  logic TICK;
  logic START_STOP;
  logic CLEAR;
  logic LAP;
  bcd_t SEC_U;
  bcd_t SEC_T;
  bcd_t MIN_U;
  bcd_t MIN_T;
  logic RUNNING;
  logic OVERFLOW;
  logic LAP_HOLD;

  modport master (
    output TICK, START_STOP, CLEAR, LAP,
    input  SEC_U, SEC_T, MIN_U, MIN_T, RUNNING, OVERFLOW, LAP_HOLD
  );

  modport slave (
    input  TICK, START_STOP, CLEAR, LAP,
    output SEC_U, SEC_T, MIN_U, MIN_T, RUNNING, OVERFLOW, LAP_HOLD
  );
endinterface

// File: rtl/stopwatch_counter_bcd_digit.sv
// One wrapping BCD digit; CARRY fires in the same cycle as the wrap.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic INC,
  output bcd_t Q,
  output logic CARRY
);

  always_comb CARRY = INC && (Q == MAX);

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      Q <= '0;
    end else if (INC) begin
      Q <= (Q == MAX) ? '0 : Q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch MM:SS time base driven by the divider tick.
// Optional lap freeze of the display is built when LAP_HOLD_EN is defined.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input logic          CLK,
  input logic          RST,
  stopwatch_counter_if.slave bus
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic tick_s1, tick_s2, tick_s3, tick_rise;
  state_t state;
  logic running_q, overflow_q;
  logic [PW-1:0] presc;
  logic count_en, sec_inc, clr_cnt;
  logic c_sec_u, c_sec_t, c_min_u, c_min_t;
  bcd_t sec_u, sec_t, min_u, min_t;

  // The edge pulse is itself registered so it lands two edges after TICK is first sampled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_s3   <= 1'b0;
      tick_rise <= 1'b0;
    end else begin
      tick_s1   <= bus.TICK;
      tick_s2   <= tick_s1;
      tick_s3   <= tick_s2;
      tick_rise <= tick_s2 & ~tick_s3;
    end
  end

  always_comb begin
    count_en = tick_rise && (state == RUN);
    sec_inc  = count_en && (presc == PRESC_LAST);
    clr_cnt  = bus.CLEAR && (state != RUN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
      presc      <= '0;
    end else begin
      if (clr_cnt) begin
        presc <= '0;
      end else if (count_en) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
      end

      if (clr_cnt) begin
        overflow_q <= 1'b0;
      end else if (c_min_t) begin
        overflow_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!bus.CLEAR && bus.START_STOP) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.START_STOP) begin
            state     <= PAUSE;
            running_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.CLEAR) begin
            state <= IDLE;
          end else if (bus.START_STOP) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  bcd_digit #(.MAX(SEC_U_MAX)) u_sec_u (
    .CLK(CLK), .RST(RST), .CLR(clr_cnt), .INC(sec_inc), .Q(sec_u), .CARRY(c_sec_u)
  );
  bcd_digit #(.MAX(SEC_T_MAX)) u_sec_t (
    .CLK(CLK), .RST(RST), .CLR(clr_cnt), .INC(c_sec_u), .Q(sec_t), .CARRY(c_sec_t)
  );
  bcd_digit #(.MAX(MIN_U_MAX)) u_min_u (
    .CLK(CLK), .RST(RST), .CLR(clr_cnt), .INC(c_sec_t), .Q(min_u), .CARRY(c_min_u)
  );
  bcd_digit #(.MAX(MIN_T_MAX)) u_min_t (
    .CLK(CLK), .RST(RST), .CLR(clr_cnt), .INC(c_min_u), .Q(min_t), .CARRY(c_min_t)
  );

  always_comb begin
    bus.RUNNING  = running_q;
    bus.OVERFLOW = overflow_q;
  end

`ifdef LAP_HOLD_EN
  logic lap_hold_q;
  bcd_t snap_sec_u, snap_sec_t, snap_min_u, snap_min_t;

  // Snapshot is taken only on the LAP that freezes; counting keeps running underneath.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lap_hold_q <= 1'b0;
      snap_sec_u <= '0;
      snap_sec_t <= '0;
      snap_min_u <= '0;
      snap_min_t <= '0;
    end else if (state == RUN) begin
      if (bus.START_STOP) begin
        lap_hold_q <= 1'b0;
      end else if (bus.LAP) begin
        lap_hold_q <= ~lap_hold_q;
        if (!lap_hold_q) begin
          snap_sec_u <= sec_u;
          snap_sec_t <= sec_t;
          snap_min_u <= min_u;
          snap_min_t <= min_t;
        end
      end
    end else if (bus.LAP || bus.CLEAR) begin
      lap_hold_q <= 1'b0;
    end
  end

  always_comb begin
    bus.LAP_HOLD = lap_hold_q;
    bus.SEC_U    = lap_hold_q ? snap_sec_u : sec_u;
    bus.SEC_T    = lap_hold_q ? snap_sec_t : sec_t;
    bus.MIN_U    = lap_hold_q ? snap_min_u : min_u;
    bus.MIN_T    = lap_hold_q ? snap_min_t : min_t;
  end
`else
  always_comb begin
    bus.LAP_HOLD = 1'b0;
    bus.SEC_U    = sec_u;
    bus.SEC_T    = sec_t;
    bus.MIN_U    = min_u;
    bus.MIN_T    = min_t;
  end
`endif

endmodule
